minterm_eval: RTL and testbench
===============================

# minterm_eval

Parametrised, pipelined sum-of-minterms evaluator. Takes an N-bit input word, decodes it to a one-hot 2^N vector, and ORs the decoded lines selected by a run-time programmable minterm mask to produce a registered boolean output. It replaces fixed decoder-plus-OR-gate function blocks. The mask is reloadable through a serial configuration port, and the block keeps a saturating count of true evaluations.

## Interface

Parameters:
- N, 4, input word width; decoded width M = 2^N.
- DEFAULT_MASK, 16'hA352, reset value of the active mask, M bits; bit i set means minterm i is in the function. The default selects minterms 1, 4, 6, 8, 9, 13 and 15.
- CNT_W, 16, width of the hit counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_start  in  1  begins a mask load; restarts any load already in progress.
- cfg_bit_valid  in  1  cfg_bit is valid this cycle.
- cfg_bit  in  1  serial mask bit, minterm 0 first.
- cfg_busy  out  1  high while in LOAD.
- cfg_done  out  1  one-cycle pulse when the new mask is committed.
- in_valid  in  1  in_w and en are valid this cycle.
- in_w  in  N  input word.
- en  in  1  decoder enable; 0 forces the decode to all-zero.
- out_valid  out  1  out_y and out_f are valid.
- out_y  out  M  registered one-hot decode; bit k is set iff w == k and en == 1.
- out_f  out  1  function result.
- hit_clr  in  1  synchronous clear of hit_count.
- hit_count  out  CNT_W  saturating count of out_valid & out_f.

## Operation

- Configuration FSM has two states, IDLE and LOAD.
  - IDLE to LOAD on cfg_start. Load index cnt is set to 0 and the shadow register is cleared.
  - In LOAD, each cfg_bit_valid writes cfg_bit into shadow[cnt] and increments cnt.
  - On the valid bit with cnt == M-1: the shadow register, including that bit, is copied to the active mask, cfg_done pulses, and the FSM returns to IDLE.
  - cfg_start while in LOAD resets cnt to 0 and discards the partial shadow. If cfg_start and cfg_bit_valid occur together, cfg_start wins and the bit is dropped.
  - cfg_bit_valid in IDLE is ignored.
  - The active mask changes only on commit. A partial load never affects out_f.
- Pipeline stage 1: on in_valid, decode in_w and en into the one-hot register and set v1. When in_valid is low, v1 is cleared and the one-hot register holds its value.
- Pipeline stage 2:
  - out_y <= stage-1 one-hot.
  - out_f <= |(stage-1 one-hot & active mask).
  - out_valid <= v1.
- en == 0 with in_valid still produces an output with out_valid = 1, out_y = 0 and out_f = 0.
- Hit counter:
  - hit_count increments at each edge where out_valid & out_f is already high.
  - It saturates at 2^CNT_W - 1.
  - hit_clr has priority over the increment; the counter reads 0 on the next cycle.

## Timing

- Reset values:
  - State IDLE, cnt = 0, shadow = 0, active mask = DEFAULT_MASK.
  - cfg_busy = 0, cfg_done = 0.
  - out_valid = 0, out_y = 0, out_f = 0, hit_count = 0, v1 = 0.
- Latency is 2 cycles: an input sampled at edge t is presented with out_valid high after edge t+1. Throughput is one input per cycle with no stalls.
- cfg_busy rises the cycle after cfg_start and falls in the same cycle cfg_done rises.
- A mask load takes M valid bits; gaps in cfg_bit_valid are allowed.
- At the commit edge, stage 2 still uses the old mask. Stage-2 updates from the following edge onward use the new mask.
- Assertion of rst_n at any time returns the block to its reset values, including mid-load; an aborted load does not commit.

## Test plan

- Reset and sweep: after reset, drive in_w = 0..15 back-to-back with en = 1. out_valid rises 2 cycles after the first input. out_f = 1 exactly for w ∈ {1,4,6,8,9,13,15}, out_y is one-hot 1<<w each cycle, and hit_count ends at 7.
- Enable low: in_valid = 1, en = 0, w = 6 -> out_valid = 1, out_y = 0, out_f = 0; hit_count is unchanged.
- Reprogram: cfg_start, then 16 bits encoding 16'h0001 with gaps between bits.
  - cfg_busy is high throughout and cfg_done pulses once.
  - After commit, w = 0 gives out_f = 1 and w = 1 gives out_f = 0.
  - An input in flight at the commit edge is evaluated with 16'hA352.
- Restart and ignore:
  - Load 8 bits, then cfg_start.
  - Load the full 16 bits of 16'h8000; the active mask becomes exactly 16'h8000.
  - cfg_bit_valid pulses in IDLE leave the mask unchanged.
- Counter: with CNT_W = 4, feed 20 true evaluations and hit_count holds at 15. Assert hit_clr together with a true output and hit_count reads 0 on the next cycle.
- Async reset mid-load: drop rst_n after 10 config bits and mid-stream. All outputs go to 0 immediately, and after release w = 13 gives out_f = 1, confirming the default mask is restored.

Source files
------------

// File: rtl/minterm_eval.sv
// Sum-of-minterms evaluator: one-hot decode of in_w, OR of the decoded lines
// selected by a serially reloadable mask, plus a saturating count of true results.
module minterm_eval #(
  parameter int                N            = 4,
  parameter logic [2**N-1:0]   DEFAULT_MASK = 16'hA352,
  parameter int                CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic              cfg_bit_valid,
  input  logic              cfg_bit,
  output logic              cfg_busy,
  output logic              cfg_done,
  output logic              cfg_state_dbg,
  input  logic              in_valid,
  input  logic [N-1:0]      in_w,
  input  logic              en,
  output logic              out_valid,
  output logic [2**N-1:0]   out_y,
  output logic              out_f,
  input  logic              hit_clr,
  output logic [CNT_W-1:0]  hit_count
);

  localparam int M = 2**N;

  // Handshake: cfg_bit is consumed on any cycle cfg_bit_valid is high while in
  // LOAD and cfg_start is low; in_valid has no back-pressure (one word per cycle).

  typedef enum logic {
    S_IDLE = 1'b0,
    S_LOAD = 1'b1
  } cfg_state_t;

  cfg_state_t   r_state;
  cfg_state_t   w_state_nxt;
  logic [N-1:0] r_cnt;
  logic [N-1:0] w_cnt_nxt;
  logic [M-1:0] r_shadow;
  logic [M-1:0] w_shadow_nxt;
  logic [M-1:0] r_mask;
  logic [M-1:0] w_mask_nxt;
  logic         w_commit;
  logic         r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_shadow <= '0;
      r_mask   <= DEFAULT_MASK;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_shadow <= w_shadow_nxt;
      r_mask   <= w_mask_nxt;
      r_done   <= w_commit;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_shadow_nxt = r_shadow;
    w_mask_nxt   = r_mask;
    w_commit     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cfg_start) begin
          w_state_nxt  = S_LOAD;
          w_cnt_nxt    = '0;
          w_shadow_nxt = '0;
        end
      end
      S_LOAD: begin
        // A restart takes precedence over a bit arriving in the same cycle.
        if (cfg_start) begin
          w_cnt_nxt    = '0;
          w_shadow_nxt = '0;
        end else if (cfg_bit_valid) begin
          w_shadow_nxt[r_cnt] = cfg_bit;
          w_cnt_nxt           = r_cnt + 1'b1;
          if (&r_cnt) begin
            w_commit    = 1'b1;
            w_mask_nxt  = w_shadow_nxt;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign cfg_busy      = (r_state == S_LOAD);
  assign cfg_done      = r_done;
  assign cfg_state_dbg = (r_state == S_LOAD);

  logic [M-1:0] w_dec;
  logic [M-1:0] r_y1;
  logic         r_v1;

  assign w_dec = {{(M-1){1'b0}}, 1'b1} << in_w;

  // The one-hot register holds across idle cycles; only v1 tracks in_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_y1 <= '0;
    end else begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_y1 <= en ? w_dec : '0;
      end
    end
  end

  logic         r_out_valid;
  logic [M-1:0] r_out_y;
  logic         r_out_f;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_y     <= '0;
      r_out_f     <= 1'b0;
    end else begin
      r_out_valid <= r_v1;
      r_out_y     <= r_y1;
      r_out_f     <= |(r_y1 & r_mask);
    end
  end

  assign out_valid = r_out_valid;
  assign out_y     = r_out_y;
  assign out_f     = r_out_f;

  logic [CNT_W-1:0] r_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit <= '0;
    end else if (hit_clr) begin
      r_hit <= '0;
    end else if (r_out_valid && r_out_f && !(&r_hit)) begin
      r_hit <= r_hit + 1'b1;
    end
  end

  assign hit_count = r_hit;

endmodule

// File: tb/tb_minterm_eval.sv
// Directed and random checks of minterm_eval against a queue/bit-list model,
// with a second instance at CNT_W = 4 to exercise counter saturation.
module tb_minterm_eval;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cfg_start = 1'b0;
  logic        cfg_bit_valid = 1'b0;
  logic        cfg_bit = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_w = '0;
  logic        en = 1'b0;
  logic        hit_clr = 1'b0;

  logic        cfg_busy, cfg_done, dbg, out_valid, out_f;
  logic [15:0] out_y;
  logic [15:0] hit16;
  logic        busy4, done4, dbg4, v4, f4;
  logic [15:0] y4;
  logic [3:0]  hit4;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  minterm_eval dut16 (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_bit_valid(cfg_bit_valid),
    .cfg_bit(cfg_bit), .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_state_dbg(dbg),
    .in_valid(in_valid), .in_w(in_w), .en(en), .out_valid(out_valid), .out_y(out_y),
    .out_f(out_f), .hit_clr(hit_clr), .hit_count(hit16)
  );

  minterm_eval #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_bit_valid(cfg_bit_valid),
    .cfg_bit(cfg_bit), .cfg_busy(busy4), .cfg_done(done4), .cfg_state_dbg(dbg4),
    .in_valid(in_valid), .in_w(in_w), .en(en), .out_valid(v4), .out_y(y4),
    .out_f(f4), .hit_clr(hit_clr), .hit_count(hit4)
  );

  typedef struct {
    logic       v;
    logic [3:0] w;
    logic       e;
  } in_t;

  // Reference model state
  in_t         in_q[$];
  logic        load_bits[$];
  logic        loading;
  logic [15:0] mask_m;
  int          m_cnt16, m_cnt4;
  logic        e_valid, e_f, e_done;
  logic [15:0] e_y;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    in_q.delete();
    load_bits.delete();
    loading = 1'b0;
    mask_m  = 16'hA352;
    m_cnt16 = 0;
    m_cnt4  = 0;
    e_valid = 1'b0;
    e_f     = 1'b0;
    e_done  = 1'b0;
    e_y     = '0;
  endtask

  task automatic tick();
    in_t ent;
    @(posedge clk);
    if (hit_clr) begin
      m_cnt16 = 0;
      m_cnt4  = 0;
    end else if (e_valid && e_f) begin
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt4 < 15) m_cnt4++;
    end
    // The word sampled one edge ago is presented now, judged by the mask
    // that was in force before this edge.
    e_valid = 1'b0;
    if (in_q.size() > 0) begin
      ent     = in_q.pop_front();
      e_valid = ent.v;
      e_y     = ent.e ? 16'(32'd1 << ent.w) : 16'h0000;
      e_f     = ent.e & mask_m[ent.w];
    end
    ent.v = in_valid;
    ent.w = in_w;
    ent.e = en;
    in_q.push_back(ent);
    e_done = 1'b0;
    if (cfg_start) begin
      loading = 1'b1;
      load_bits.delete();
    end else if (loading && cfg_bit_valid) begin
      load_bits.push_back(cfg_bit);
      if (load_bits.size() == 16) begin
        for (int i = 0; i < 16; i++) mask_m[i] = load_bits[i];
        loading = 1'b0;
        e_done  = 1'b1;
      end
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(e_valid));
    chk("out_valid4", 32'(v4), 32'(e_valid));
    if (e_valid) begin
      chk("out_y", 32'(out_y), 32'(e_y));
      chk("out_f", 32'(out_f), 32'(e_f));
      chk("out_y4", 32'(y4), 32'(e_y));
      chk("out_f4", 32'(f4), 32'(e_f));
    end
    chk("cfg_busy", 32'(cfg_busy), 32'(loading));
    chk("cfg_busy4", 32'(busy4), 32'(loading));
    chk("dbg_state", 32'(dbg), 32'(loading));
    chk("dbg_state4", 32'(dbg4), 32'(loading));
    chk("cfg_done", 32'(cfg_done), 32'(e_done));
    chk("cfg_done4", 32'(done4), 32'(e_done));
    chk("hit_count16", 32'(hit16), 32'(m_cnt16));
    chk("hit_count4", 32'(hit4), 32'(m_cnt4));
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_y", 32'(out_y), 32'd0);
    chk("rst_out_f", 32'(out_f), 32'd0);
    chk("rst_hit16", 32'(hit16), 32'd0);
    chk("rst_hit4", 32'(hit4), 32'd0);
    chk("rst_busy", 32'(cfg_busy), 32'd0);
    chk("rst_done", 32'(cfg_done), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic idle_inputs();
    cfg_start     = 1'b0;
    cfg_bit_valid = 1'b0;
    cfg_bit       = 1'b0;
    in_valid      = 1'b0;
    en            = 1'b0;
    hit_clr       = 1'b0;
  endtask

  initial begin
    logic [15:0] pat;
    model_reset();
    #1;
    apply_reset();

    // Sweep every word with the default mask
    for (int w = 0; w < 16; w++) begin
      in_valid = 1'b1; in_w = 4'(w); en = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    chk("sweep_hits", 32'(hit16), 32'd7);

    // Enable low still yields a valid, all-zero result
    in_valid = 1'b1; in_w = 4'd6; en = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    chk("en0_valid", 32'(out_valid), 32'd1);
    chk("en0_y", 32'(out_y), 32'd0);
    chk("en0_f", 32'(out_f), 32'd0);
    tick();
    chk("en0_hits", 32'(hit16), 32'd7);

    // Load 16'h0001 with gaps; w=1 is in flight at the commit edge
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cfg_bit_valid = 1'b0;
      if (i == 15) begin
        in_valid = 1'b1; in_w = 4'd1; en = 1'b1;
      end
      tick();
      in_valid      = 1'b0;
      cfg_bit_valid = 1'b1;
      cfg_bit       = (i == 0);
      tick();
    end
    cfg_bit_valid = 1'b0;
    chk("commit_done", 32'(cfg_done), 32'd1);
    chk("inflight_old_mask", 32'(out_f), 32'd1);
    in_valid = 1'b1; in_w = 4'd0; en = 1'b1;
    tick();
    in_w = 4'd1;
    tick();
    chk("new_mask_w0", 32'(out_f), 32'd1);
    in_valid = 1'b0;
    tick();
    chk("new_mask_w1", 32'(out_f), 32'd0);

    // Partial load, restart (with a colliding bit), then full 16'h8000 load
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cfg_bit_valid = 1'b1; cfg_bit = 1'($urandom);
      tick();
    end
    cfg_start = 1'b1; cfg_bit = 1'b1;
    tick();
    cfg_start = 1'b0;
    pat = 16'h8000;
    for (int i = 0; i < 16; i++) begin
      cfg_bit = pat[i];
      tick();
    end
    // Bits offered while idle must be ignored
    repeat (5) begin
      cfg_bit = 1'($urandom);
      tick();
    end
    cfg_bit_valid = 1'b0;
    for (int w = 0; w < 16; w++) begin
      in_valid = 1'b1; in_w = 4'(w); en = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("mask8000_w15", 32'(out_f), 32'd1);
    tick();

    // Saturation in the 4-bit counter, then clear against a true result
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_w = 4'd15; en = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    chk("sat_hit4", 32'(hit4), 32'd15);
    in_valid = 1'b1; in_w = 4'd15; en = 1'b1;
    tick();
    tick();
    hit_clr = 1'b1;
    tick();
    hit_clr = 1'b0;
    chk("clr_hit4", 32'(hit4), 32'd0);
    chk("clr_hit16", 32'(hit16), 32'd0);
    tick();
    in_valid = 1'b0;
    repeat (2) tick();

    // Asynchronous reset in the middle of a load and a stream
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cfg_bit_valid = 1'b1; cfg_bit = 1'($urandom);
      in_valid = 1'b1; in_w = 4'($urandom_range(0, 15)); en = 1'b1;
      tick();
    end
    apply_reset();
    idle_inputs();
    in_valid = 1'b1; in_w = 4'd13; en = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("post_reset_w13", 32'(out_f), 32'd1);
    tick();

    // Random traffic with occasional reloads, idle bits and clears
    for (int c = 0; c < 600; c++) begin
      in_valid      = ($urandom_range(0, 3) != 0);
      in_w          = 4'($urandom_range(0, 15));
      en            = ($urandom_range(0, 4) != 0);
      cfg_start     = ($urandom_range(0, 60) == 0);
      cfg_bit_valid = 1'($urandom_range(0, 1));
      cfg_bit       = 1'($urandom);
      hit_clr       = ($urandom_range(0, 80) == 0);
      tick();
    end
    idle_inputs();
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
